demux_2to8_packer: RTL



---
 rtl/demux_2to8_packer.sv | 79 +++++++
 1 files changed

// File: rtl/demux_2to8_packer.sv
// Packs a stream of narrow symbols into wide words, slot 0 in the low bits.
// Valid/ready on both sides; flush emits a zero-filled partial word.
module demux_2to8_packer #(
  parameter int SYM_W    = 2,
  parameter int NUM_SYMS = 4,
  parameter int CNT_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SYM_W-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [SYM_W*NUM_SYMS-1:0] out_data,
  output logic [CNT_W-1:0]          out_count,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      flush,
  output logic                      flush_ack
);

  localparam int OUT_W  = SYM_W * NUM_SYMS;
  localparam int SLOT_W = (NUM_SYMS > 1) ? $clog2(NUM_SYMS) : 1;
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NUM_SYMS - 1);

  logic [SLOT_W-1:0] slot;
  logic [OUT_W-1:0]  acc;
  logic [OUT_W-1:0]  merged;
  logic [CNT_W-1:0]  n;
  logic              can_load;
  logic              in_fire;
  logic              flush_take;
  logic              load;

  assign can_load   = !out_valid || out_ready;
  assign in_ready   = rst_n && ((slot != LAST) || can_load);
  assign in_fire    = in_valid && in_ready;
  assign flush_take = flush && can_load;
  assign n          = CNT_W'(slot) + CNT_W'(in_fire);

  // A same-cycle symbol is folded in before any load.
  always_comb begin
    merged = acc;
    if (in_fire) begin
      merged[slot*SYM_W +: SYM_W] = in_data;
    end
  end

  assign load = (flush_take && (n != '0)) ||
                (in_fire && (slot == LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      flush_ack <= 1'b0;
      slot      <= '0;
      acc       <= '0;
    end else begin
      flush_ack <= flush_take;
      if (load) begin
        out_data  <= merged;
        out_count <= n;
        out_valid <= 1'b1;
        slot      <= '0;
        acc       <= '0;
      end else begin
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
        if (in_fire) begin
          acc  <= merged;
          slot <= slot + 1'b1;
        end
      end
    end
  end

endmodule
